// File: rtl/cpu_defs.sv
// cpu_defs: shared opcodes, IF/ID bundle and range helper for the MIPS core
package cpu_defs;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;
  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
  function automatic logic in_range(input logic [31:0] addr, input int words);
    return addr < 32'(words * 4);
  endfunction
endpackage

// File: rtl/fetch_target_calc.sv
// fetch_target_calc: branch and jump targets relative to the instruction in ID
module fetch_target_calc (
  input  logic [31:0] pc_plus4,
  input  logic [15:0] offset,
  input  logic [25:0] index,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target
);
  assign branch_target = pc_plus4 + {{14{offset[15]}}, offset, 2'b00};
  assign jump_target = {pc_plus4[31:28], index, 2'b00};
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, IF/ID register, redirects, stalls and end-of-program halt
module instruction_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_WORDS = 30
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ReadAddress,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [15:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        Halted,
  output logic [31:0] FetchCount
);
  logic [31:0] pc, branch_target, jump_target, target;
  if_id_t if_id;
  fetch_target_calc u_calc (
    .pc_plus4(if_id.pc_plus4),
    .offset(BranchOffset),
    .index(JumpIndex),
    .branch_target(branch_target),
    .jump_target(jump_target)
  );
  assign target = Jump ? jump_target : branch_target;
  assign ReadAddress = pc;
  assign IF_ID_Instruction = if_id.instr;
  assign IF_ID_PCPlus4 = if_id.pc_plus4;
  assign IF_ID_Valid = if_id.valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      if_id <= BUBBLE;
      Halted <= 1'b0;
      FetchCount <= 32'h0;
    end else if (Jump || Branch) begin
      pc <= target;
      if_id <= BUBBLE;
      Halted <= !in_range(target, MEM_WORDS);
    end else if (!Stall) begin
      if (in_range(pc, MEM_WORDS)) begin
        pc <= pc + 32'd4;
        if_id <= '{instr: Instruction, pc_plus4: pc + 32'd4, valid: 1'b1};
        FetchCount <= FetchCount + 32'd1;
      end else begin
        if_id <= BUBBLE;
        Halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plan plus randomized run against a behavioural model
module tb_instruction_fetch_unit;
  import cpu_defs::*;
  localparam int WORDS = 30;
  localparam logic [31:0] LIMIT = 32'(WORDS * 4);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] ReadAddress, Instruction, IF_ID_Instruction, IF_ID_PCPlus4, FetchCount;
  logic Stall = 1'b0, Branch = 1'b0, Jump = 1'b0;
  logic [15:0] BranchOffset = '0;
  logic [25:0] JumpIndex = '0;
  logic IF_ID_Valid, Halted;
  logic [31:0] mem [0:31];
  int tests = 0, fails = 0;
  logic m_known = 1'b0;
  logic [31:0] m_pc, m_instr, m_pcp4, m_count, m_tgt;
  logic m_valid, m_halted;
  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .ReadAddress(ReadAddress), .Instruction(Instruction),
    .Stall(Stall), .Branch(Branch), .BranchOffset(BranchOffset), .Jump(Jump),
    .JumpIndex(JumpIndex), .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .Halted(Halted), .FetchCount(FetchCount)
  );
  always #5 clk = ~clk;
  assign Instruction = (ReadAddress < LIMIT) ? mem[ReadAddress[6:2]] : 32'hDEAD_BEEF;
  assign m_tgt = Jump ? {m_pcp4[31:28], JumpIndex, 2'b00}
                      : m_pcp4 + 32'($signed(BranchOffset) * 4);
  always @(posedge clk) begin
    assert (!(Jump && Branch)) else $error("illegal stimulus: Jump and Branch together");
    if (reset) begin
      m_known <= 1'b1;
      m_pc <= 32'h0;
      m_instr <= 32'h0;
      m_pcp4 <= 32'h0;
      m_valid <= 1'b0;
      m_halted <= 1'b0;
      m_count <= 32'h0;
    end else if (Jump || Branch) begin
      m_pc <= m_tgt;
      m_instr <= 32'h0;
      m_pcp4 <= 32'h0;
      m_valid <= 1'b0;
      m_halted <= m_tgt >= LIMIT;
    end else if (!Stall && m_pc < LIMIT) begin
      m_pc <= m_pc + 4;
      m_instr <= mem[m_pc / 4];
      m_pcp4 <= m_pc + 4;
      m_valid <= 1'b1;
      m_count <= m_count + 1;
    end else if (!Stall) begin
      m_instr <= 32'h0;
      m_pcp4 <= 32'h0;
      m_valid <= 1'b0;
      m_halted <= 1'b1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (m_known) begin
      chk("model ReadAddress", ReadAddress, m_pc);
      chk("model IF_ID_Instruction", IF_ID_Instruction, m_instr);
      chk("model IF_ID_PCPlus4", IF_ID_PCPlus4, m_pcp4);
      chk("model IF_ID_Valid", 32'(IF_ID_Valid), 32'(m_valid));
      chk("model Halted", 32'(Halted), 32'(m_halted));
      chk("model FetchCount", FetchCount, m_count);
    end
  end
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] held;
    bit hit;
    for (int i = 0; i < 32; i++) mem[i] = (i % 5 == 0) ? {OP_BEQ, 26'($urandom)} : $urandom;
    mem[7] = {OP_J, 26'h15};
    cyc();
    reset = 1'b0;
    chk("reset ReadAddress", ReadAddress, 32'h0);
    chk("reset Valid", 32'(IF_ID_Valid), 32'h0);
    chk("reset FetchCount", FetchCount, 32'h0);
    chk("reset Halted", 32'(Halted), 32'h0);
    cyc();
    chk("run ReadAddress 4", ReadAddress, 32'h4);
    cyc();
    chk("run ReadAddress 8", ReadAddress, 32'h8);
    cyc();
    chk("run PCPlus4 C", IF_ID_PCPlus4, 32'hC);
    chk("run Valid", 32'(IF_ID_Valid), 32'h1);
    chk("run FetchCount 3", FetchCount, 32'h3);
    chk("run Instruction", IF_ID_Instruction, mem[2]);
    repeat (6) cyc();
    chk("pre-branch PCPlus4", IF_ID_PCPlus4, 32'h24);
    Branch = 1'b1;
    BranchOffset = 16'h0009;
    cyc();
    Branch = 1'b0;
    chk("branch fwd PC", ReadAddress, 32'h48);
    chk("branch fwd bubble", 32'(IF_ID_Valid), 32'h0);
    chk("branch fwd count", FetchCount, 32'h9);
    cyc();
    chk("after branch PCPlus4", IF_ID_PCPlus4, 32'h4C);
    chk("after branch Valid", 32'(IF_ID_Valid), 32'h1);
    Jump = 1'b1;
    JumpIndex = 26'hF;
    cyc();
    Jump = 1'b0;
    cyc();
    chk("pre-back PCPlus4", IF_ID_PCPlus4, 32'h40);
    Branch = 1'b1;
    BranchOffset = 16'hFFFC;
    cyc();
    Branch = 1'b0;
    chk("branch back PC", ReadAddress, 32'h30);
    Jump = 1'b1;
    JumpIndex = 26'hE;
    Stall = 1'b1;
    cyc();
    Jump = 1'b0;
    Stall = 1'b0;
    chk("jump over stall PC", ReadAddress, 32'h38);
    chk("jump over stall bubble", IF_ID_Instruction, 32'h0);
    Jump = 1'b1;
    JumpIndex = 26'h4;
    cyc();
    Jump = 1'b0;
    Stall = 1'b1;
    held = FetchCount;
    repeat (2) begin
      cyc();
      chk("stall PC", ReadAddress, 32'h10);
      chk("stall count", FetchCount, held);
      chk("stall Valid", 32'(IF_ID_Valid), 32'h0);
    end
    Stall = 1'b0;
    cyc();
    chk("release PCPlus4", IF_ID_PCPlus4, 32'h14);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (ReadAddress == 32'h78) hit = 1'b1;
      else cyc();
    end
    chk("reach end of program", 32'(hit), 32'h1);
    cyc();
    chk("halt PC", ReadAddress, 32'h78);
    chk("halt flag", 32'(Halted), 32'h1);
    chk("halt bubble", 32'(IF_ID_Valid), 32'h0);
    cyc();
    chk("halt holds", ReadAddress, 32'h78);
    Jump = 1'b1;
    JumpIndex = 26'h0;
    cyc();
    Jump = 1'b0;
    chk("unhalt PC", ReadAddress, 32'h0);
    chk("unhalt flag", 32'(Halted), 32'h0);
    repeat (3) cyc();
    Branch = 1'b1;
    BranchOffset = 16'h5;
    Stall = 1'b1;
    reset = 1'b1;
    cyc();
    {Branch, Stall, reset} = 3'b000;
    chk("mid reset PC", ReadAddress, 32'h0);
    chk("mid reset count", FetchCount, 32'h0);
    chk("mid reset PCPlus4", IF_ID_PCPlus4, 32'h0);
    chk("mid reset Valid", 32'(IF_ID_Valid), 32'h0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(99) == 0;
      Stall = $urandom_range(3) == 0;
      Jump = $urandom_range(19) == 0;
      Branch = !Jump && $urandom_range(9) == 0;
      BranchOffset = 16'($signed($urandom_range(40)) - 20);
      JumpIndex = 26'($urandom_range(40));
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface, and the IF stage of the pipelined MIPS core.
- Holds the PC and drives ReadAddress to the combinational Instruction_memory.
- Captures the returned Instruction, plus PC+4, into the IF/ID pipeline register.
- Handles redirects (branch/jump resolved in ID), hazard stalls, and end-of-program halting.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_WORDS, 30, number of valid instruction words; byte addresses >= MEM_WORDS*4 are out of program

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
ReadAddress  output  32  byte address to instruction memory, equal to PC (combinational)
Instruction  input  32  word returned by memory for ReadAddress in the same cycle
Stall  input  1  hazard unit: hold PC and IF/ID
Branch  input  1  ID resolved a taken beq
BranchOffset  input  16  signed word offset from the ID-stage instruction
Jump  input  1  ID holds a j instruction
JumpIndex  input  26  j target field
IF_ID_Instruction  output  32  registered instruction to ID
IF_ID_PCPlus4  output  32  registered PC+4 of that instruction
IF_ID_Valid  output  1  1 = real instruction, 0 = bubble
Halted  output  1  sticky: PC has left the program range
FetchCount  output  32  number of valid instructions captured into IF/ID

Behaviour:
Reset values, applied on the first clk edge with reset=1; reset overrides all other inputs:
- PC=RESET_PC
- IF_ID_Instruction=0 (nop), IF_ID_PCPlus4=0, IF_ID_Valid=0
- Halted=0, FetchCount=0

General:
- ReadAddress = PC, purely combinational.
- Memory latency is 0, so Instruction is sampled on the same edge that advances PC.
- InRange = (PC < MEM_WORDS*4), 32-bit unsigned compare.

Targets, computed from the registered IF_ID_PCPlus4 (the instruction currently in ID):
- BranchTarget = IF_ID_PCPlus4 + ({{14{BranchOffset[15]}}, BranchOffset, 2'b00}), modulo 2^32, wrap allowed.
- JumpTarget = {IF_ID_PCPlus4[31:28], JumpIndex, 2'b00}.

Per-edge priority, highest first:
1. reset: load reset values.
2. Jump: PC<=JumpTarget; IF/ID <= bubble (Instruction 0, Valid 0, PCPlus4 0). The wrong-path fetch is discarded.
3. Branch: same as Jump but uses BranchTarget.
   - Jump and Branch together is illegal stimulus; Jump wins and the bench asserts on it.
4. Stall: PC, IF/ID, FetchCount all hold. A redirect (rows 2-3) overrides Stall.
5. Normal, InRange:
   - PC<=PC+4
   - IF_ID_Instruction<=Instruction, IF_ID_PCPlus4<=PC+4, IF_ID_Valid<=1
   - FetchCount<=FetchCount+1 (wraps at 2^32)
6. Normal, !InRange:
   - PC holds; IF/ID <= bubble; Halted<=1.
   - Instruction is never sampled out of range.

Halted:
- Sticky, cleared only by reset or by a redirect to an in-range target.
- Halted is updated from the new PC on every redirect.

Other rules:
- No state is bit-indexed by misaligned addresses; PC[1:0] is always 0 because all targets end in 2'b00.
- Reset mid-stall or mid-redirect behaves as plain reset; no pending state survives.

Decomposition:
Shared package cpu_defs:
- NOP_INSTR = 32'h0
- opcode constants OP_J = 6'b000010, OP_BEQ = 6'b000100 (used by ID and the bench)
- the IF/ID bundle fields

One sub-module, fetch_target_calc: combinational BranchTarget/JumpTarget from IF_ID_PCPlus4, BranchOffset, JumpIndex. The PC register, IF/ID register, halt flag and counter remain in the top.

Test Plan:
1. Reset then free run, no Stall/Branch/Jump: ReadAddress 0,4,8; after 3 edges IF_ID_PCPlus4=0xC, IF_ID_Valid=1, FetchCount=3.
2. Branch=1, BranchOffset=16'h0009 with IF_ID_PCPlus4=0x24: next edge PC=0x48, IF_ID_Valid=0, FetchCount unchanged; following edge IF_ID_PCPlus4=0x4C, IF_ID_Valid=1. Repeat with BranchOffset=16'hFFFC and IF_ID_PCPlus4=0x40: PC=0x30.
3. Jump=1, JumpIndex=26'h0E, Stall=1 on the same edge: PC=0x38 (redirect beats stall), IF/ID bubble.
4. Stall=1 for 2 cycles at PC=0x10: PC, IF_ID_* and FetchCount constant for 2 edges; the edge after release gives IF_ID_PCPlus4=0x14.
5. Free run to PC=0x78 (MEM_WORDS=30): PC holds at 0x78, Halted=1, IF_ID_Valid=0. Then Jump with JumpIndex=0: PC=0, Halted=0.
6. reset=1 asserted during a Branch with Stall=1: all outputs return to reset values on that edge, and PC=RESET_PC.
